// File: rtl/display_mode_arbiter_pkg.sv
// Shared encodings and helpers for the display mode arbiter: owner modes,
// arbiter FSM states, the switch password decoder and the owner one-hot map.
package display_mode_arbiter_pkg;

    typedef enum logic [2:0] {
        MODE_INIT = 3'd0,
        MODE_A    = 3'd1,
        MODE_B    = 3'd2,
        MODE_C    = 3'd3,
        MODE_D    = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ST_SHOW       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_BLANK      = 2'd2
    } arb_state_e;

    // Exact-match password decode; earlier students take priority.
    function automatic mode_e decode_sw(
        input logic [15:0] sw,
        input logic [15:0] pw_a,
        input logic [15:0] pw_b,
        input logic [15:0] pw_c,
        input logic [15:0] pw_d
    );
        mode_e result;
        if (sw == pw_a) begin
            result = MODE_A;
        end else if (sw == pw_b) begin
            result = MODE_B;
        end else if (sw == pw_c) begin
            result = MODE_C;
        end else if (sw == pw_d) begin
            result = MODE_D;
        end else begin
            result = MODE_INIT;
        end
        return result;
    endfunction

    // Student enable pattern {D,C,B,A}; the init pattern owns no student.
    function automatic logic [3:0] mode_onehot(input mode_e m);
        logic [3:0] result;
        case (m)
            MODE_A:  result = 4'b0001;
            MODE_B:  result = 4'b0010;
            MODE_C:  result = 4'b0100;
            MODE_D:  result = 4'b1000;
            default: result = 4'b0000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/display_mode_arbiter_if.sv
// Bundle of the switch/frame inputs, the per-source LED and pixel requests,
// and the arbitrated outputs. The arbiter uses the master view, the
// surrounding sources and display use the slave view.
interface display_mode_arbiter_if;

    logic [15:0] sw;
    logic        frame_begin;
    logic [15:0] led_A;
    logic [15:0] led_B;
    logic [15:0] led_C;
    logic [15:0] led_D;
    logic [15:0] oled_data_A;
    logic [15:0] oled_data_B;
    logic [15:0] oled_data_C;
    logic [15:0] oled_data_D;
    logic [15:0] oled_data_init;
    logic [15:0] led;
    logic [15:0] oled_data;
    logic [3:0]  student_en;
    logic [2:0]  mode;

    modport master (
        input  sw, frame_begin,
        input  led_A, led_B, led_C, led_D,
        input  oled_data_A, oled_data_B, oled_data_C, oled_data_D, oled_data_init,
        output led, oled_data, student_en, mode
    );

    modport slave (
        output sw, frame_begin,
        output led_A, led_B, led_C, led_D,
        output oled_data_A, oled_data_B, oled_data_C, oled_data_D, oled_data_init,
        input  led, oled_data, student_en, mode
    );

endinterface

// File: rtl/display_mode_arbiter_filter.sv
// Debounce for the decoded switch mode: a new mode is only accepted once it
// has been seen unchanged for STABLE_CYCLES consecutive cycles.
module switch_stability_filter
    import display_mode_arbiter_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 62500
) (
    input  logic  clock_6p25mhz,
    input  logic  reset,
    input  mode_e decoded_mode,
    output mode_e accepted_mode
);

    localparam int unsigned CNT_W = (STABLE_CYCLES > 32'd1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 32'd1);

    mode_e            decoded_prev_r;
    logic [CNT_W-1:0] stable_cnt_r;
    mode_e            accepted_r;

    // Count how long the decoded mode has held; accept it once the count tops out.
    always_ff @(posedge clock_6p25mhz) begin
        if (reset) begin
            decoded_prev_r <= MODE_INIT;
            stable_cnt_r   <= {CNT_W{1'b0}};
            accepted_r     <= MODE_INIT;
        end else begin
            decoded_prev_r <= decoded_mode;
            if (decoded_mode != decoded_prev_r) begin
                stable_cnt_r <= {CNT_W{1'b0}};
            end else if (stable_cnt_r == CNT_LAST) begin
                // Saturated: the mode has been stable long enough.
                accepted_r <= decoded_mode;
            end else begin
                stable_cnt_r <= stable_cnt_r + CNT_W'(1);
            end
        end
    end

    assign accepted_mode = accepted_r;

endmodule

// File: rtl/display_mode_arbiter.sv
// Owns the shared LED bank and OLED pixel stream. Grants them to one of
// students A-D or the init pattern based on the debounced switch password,
// switching owner only on frame boundaries with blank frames in between.
module display_mode_arbiter
    import display_mode_arbiter_pkg::*;
#(
    parameter logic [15:0] PASSWORD_A    = 16'hA001,
    parameter logic [15:0] PASSWORD_B    = 16'hB002,
    parameter logic [15:0] PASSWORD_C    = 16'hC003,
    parameter logic [15:0] PASSWORD_D    = 16'h8195,
    parameter int unsigned STABLE_CYCLES = 62500,
    parameter int unsigned BLANK_FRAMES  = 2,
    parameter logic [15:0] BLANK_COLOUR  = 16'h0000
) (
    input  logic                   clock_6p25mhz,
    input  logic                   reset,
    display_mode_arbiter_if.master bus
);

    localparam int unsigned BCNT_W = (BLANK_FRAMES > 32'd1) ? $clog2(BLANK_FRAMES) : 1;
    // With BLANK_FRAMES == 0 the BLANK state is never entered, so this value is unused.
    localparam logic [BCNT_W-1:0] BCNT_LAST =
        (BLANK_FRAMES > 32'd0) ? BCNT_W'(BLANK_FRAMES - 32'd1) : {BCNT_W{1'b0}};

    mode_e             decoded_s;
    mode_e             accepted_s;
    logic [15:0]       src_led_s;
    logic [15:0]       src_oled_s;

    arb_state_e        state_r;
    mode_e             mode_r;
    mode_e             pending_r;
    logic [BCNT_W-1:0] blank_cnt_r;
    logic [15:0]       led_r;
    logic [15:0]       oled_data_r;
    logic [3:0]        student_en_r;

    // Raw switch pattern to requested owner.
    always_comb begin
        decoded_s = decode_sw(bus.sw, PASSWORD_A, PASSWORD_B, PASSWORD_C, PASSWORD_D);
    end

    switch_stability_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clock_6p25mhz (clock_6p25mhz),
        .reset         (reset),
        .decoded_mode  (decoded_s),
        .accepted_mode (accepted_s)
    );

    // Select the LED and pixel sources belonging to the current owner.
    always_comb begin
        src_led_s  = bus.sw;
        src_oled_s = bus.oled_data_init;
        case (mode_r)
            MODE_A: begin
                src_led_s  = bus.led_A;
                src_oled_s = bus.oled_data_A;
            end
            MODE_B: begin
                src_led_s  = bus.led_B;
                src_oled_s = bus.oled_data_B;
            end
            MODE_C: begin
                src_led_s  = bus.led_C;
                src_oled_s = bus.oled_data_C;
            end
            MODE_D: begin
                src_led_s  = bus.led_D;
                src_oled_s = bus.oled_data_D;
            end
            MODE_INIT: begin
                src_led_s  = bus.sw;
                src_oled_s = bus.oled_data_init;
            end
            default: begin
                src_led_s  = bus.sw;
                src_oled_s = bus.oled_data_init;
            end
        endcase
    end

    // Ownership FSM with registered outputs; the owner only changes on frame_begin.
    always_ff @(posedge clock_6p25mhz) begin
        if (reset) begin
            state_r      <= ST_SHOW;
            mode_r       <= MODE_INIT;
            pending_r    <= MODE_INIT;
            blank_cnt_r  <= {BCNT_W{1'b0}};
            led_r        <= 16'h0000;
            oled_data_r  <= BLANK_COLOUR;
            student_en_r <= 4'b0000;
        end else begin
            if (state_r == ST_BLANK) begin
                led_r        <= 16'h0000;
                oled_data_r  <= BLANK_COLOUR;
                student_en_r <= 4'b0000;
            end else begin
                led_r        <= src_led_s;
                oled_data_r  <= src_oled_s;
                student_en_r <= mode_onehot(mode_r);
            end

            case (state_r)
                ST_SHOW: begin
                    if (accepted_s != mode_r) begin
                        pending_r <= accepted_s;
                        state_r   <= ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (accepted_s == mode_r) begin
                        // Request withdrawn before the frame ended: keep showing.
                        state_r <= ST_SHOW;
                    end else begin
                        // Track the latest request; the commit uses the value
                        // registered before this cycle's frame_begin.
                        pending_r <= accepted_s;
                        if (bus.frame_begin) begin
                            if (BLANK_FRAMES == 32'd0) begin
                                mode_r  <= pending_r;
                                state_r <= ST_SHOW;
                            end else begin
                                blank_cnt_r <= {BCNT_W{1'b0}};
                                state_r     <= ST_BLANK;
                            end
                        end
                    end
                end
                ST_BLANK: begin
                    // Latest request wins, even a return to the old owner.
                    pending_r <= accepted_s;
                    if (bus.frame_begin) begin
                        if (blank_cnt_r == BCNT_LAST) begin
                            mode_r  <= pending_r;
                            state_r <= ST_SHOW;
                        end else begin
                            blank_cnt_r <= blank_cnt_r + BCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_SHOW;
                end
            endcase
        end
    end

    assign bus.led        = led_r;
    assign bus.oled_data  = oled_data_r;
    assign bus.student_en = student_en_r;
    assign bus.mode       = mode_r;

endmodule

// File: tb/tb_display_mode_arbiter.sv
// Directed bench for display_mode_arbiter with short debounce and two blank
// frames; frame_begin pulses once every 100 cycles.
`timescale 1ns/1ps
module tb_display_mode_arbiter;

    localparam logic [15:0] INIT_PIX = 16'h07E0;
    localparam logic [15:0] LED_A    = 16'h00A1;
    localparam logic [15:0] LED_B    = 16'h00B2;
    localparam logic [15:0] LED_C    = 16'h00C3;
    localparam logic [15:0] LED_D    = 16'h00D4;
    localparam logic [15:0] PIX_A    = 16'hF800;
    localparam logic [15:0] PIX_B    = 16'h001F;
    localparam logic [15:0] PIX_C    = 16'hFFE0;
    localparam logic [15:0] PIX_D    = 16'h7BEF;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc_cnt  = 0;
    int   bad;

    // 6.25 MHz clock
    always #80 clk = ~clk;

    display_mode_arbiter_if bus ();

    display_mode_arbiter #(
        .STABLE_CYCLES (8),
        .BLANK_FRAMES  (2)
    ) dut (
        .clock_6p25mhz (clk),
        .reset         (reset),
        .bus           (bus)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_show(input string tag, input logic [2:0] m, input logic [3:0] en,
                              input logic [15:0] l, input logic [15:0] p);
        check_eq({tag, "_mode"}, {13'd0, bus.mode}, {13'd0, m});
        check_eq({tag, "_en"},   {12'd0, bus.student_en}, {12'd0, en});
        check_eq({tag, "_led"},  bus.led, l);
        check_eq({tag, "_pix"},  bus.oled_data, p);
    endtask

    // One clock: inputs and sampling happen 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc_cnt++;
        bus.frame_begin = ((cyc_cnt % 100) == 99) ? 1'b1 : 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the DUT has sampled the next frame_begin pulse.
    task automatic run_to_frame();
        int guard;
        guard = 0;
        while (bus.frame_begin !== 1'b1 && guard < 250) begin
            tick();
            guard++;
        end
        check_eq("frame_seen", {15'd0, bus.frame_begin}, 16'd1);
        tick();
    endtask

    task automatic align();
        run_to_frame();
        ticks(3);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog cycles=%0d", cyc_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        bus.sw             = 16'h0000;
        bus.frame_begin    = 1'b0;
        bus.led_A          = LED_A;
        bus.led_B          = LED_B;
        bus.led_C          = LED_C;
        bus.led_D          = LED_D;
        bus.oled_data_A    = PIX_A;
        bus.oled_data_B    = PIX_B;
        bus.oled_data_C    = PIX_C;
        bus.oled_data_D    = PIX_D;
        bus.oled_data_init = INIT_PIX;
        ticks(2);
        check_show("reset", 3'd0, 4'b0000, 16'h0000, 16'h0000);

        // Init pattern passes switches to the LEDs
        reset  = 1'b0;
        bus.sw = 16'h1234;
        tick();
        check_show("init_pass", 3'd0, 4'b0000, 16'h1234, INIT_PIX);

        // Near-miss password stays on init
        bus.sw = 16'h8194;
        ticks(150);
        check_show("near_miss", 3'd0, 4'b0000, 16'h8194, INIT_PIX);

        // Bouncing switches never get accepted
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            bus.sw = ((i % 2) == 0) ? 16'h8195 : 16'h0000;
            for (int k = 0; k < 5; k++) begin
                tick();
                if (bus.mode !== 3'd0 || bus.oled_data !== INIT_PIX) bad++;
            end
        end
        check_eq("toggle_hold", bad[15:0], 16'd0);
        bus.sw = 16'h0000;
        ticks(12);

        // Request D, withdraw before the frame ends: no blanking
        align();
        bus.sw = 16'h8195;
        ticks(12);
        bus.sw = 16'h0000;
        ticks(12);
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (bus.mode !== 3'd0 || bus.oled_data !== INIT_PIX) bad++;
        end
        check_eq("cancel_no_blank", bad[15:0], 16'd0);

        // Grant D: two blank frames then D owns the outputs
        align();
        bus.sw = 16'h8195;
        ticks(10);
        check_show("d_before_frame", 3'd0, 4'b0000, 16'h8195, INIT_PIX);
        run_to_frame();
        ticks(2);
        check_show("d_blank1", 3'd0, 4'b0000, 16'h0000, 16'h0000);
        run_to_frame();
        ticks(2);
        check_show("d_blank2", 3'd0, 4'b0000, 16'h0000, 16'h0000);
        run_to_frame();
        ticks(2);
        check_show("d_grant", 3'd4, 4'b1000, LED_D, PIX_D);
        bus.led_D = 16'h5555;
        tick();
        check_eq("d_led_track", bus.led, 16'h5555);
        bus.led_D = LED_D;

        // Back to init through the blank sequence
        align();
        bus.sw = 16'h0000;
        ticks(12);
        run_to_frame();
        run_to_frame();
        run_to_frame();
        ticks(2);
        check_show("back_init", 3'd0, 4'b0000, 16'h0000, INIT_PIX);

        // Request D, switch to A while blanking: A wins
        align();
        bus.sw = 16'h8195;
        ticks(12);
        run_to_frame();
        ticks(5);
        check_eq("da_in_blank", bus.oled_data, 16'h0000);
        bus.sw = 16'hA001;
        ticks(12);
        run_to_frame();
        ticks(2);
        check_show("da_blank2", 3'd0, 4'b0000, 16'h0000, 16'h0000);
        run_to_frame();
        ticks(2);
        check_show("da_grant", 3'd1, 4'b0001, LED_A, PIX_A);

        // Reset in the middle of a blank sequence
        align();
        bus.sw = 16'h8195;
        ticks(12);
        run_to_frame();
        ticks(5);
        check_eq("rst_pre_blank", bus.led, 16'h0000);
        reset = 1'b1;
        tick();
        check_show("rst_mid_blank", 3'd0, 4'b0000, 16'h0000, 16'h0000);
        reset  = 1'b0;
        bus.sw = 16'h1234;
        tick();
        check_show("rst_show", 3'd0, 4'b0000, 16'h1234, INIT_PIX);
        run_to_frame();
        ticks(2);
        check_show("rst_after_frame", 3'd0, 4'b0000, 16'h1234, INIT_PIX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
